// File: rtl/instruction_encoder.sv
// instruction_encoder: packs register/immediate instruction fields into 16-bit words
// and queues them in a DEPTH-entry FIFO toward a downstream decoder.
module instruction_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     fmt_imm,
    input  logic [3:0]               opcode,
    input  logic [2:0]               rDadrs,
    input  logic                     flag,
    input  logic [2:0]               rAadrs,
    input  logic [2:0]               rBadrs,
    input  logic [7:0]               imm,
    output logic [15:0]              instruct,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   word;
    logic          push, pop;

    always_comb begin
        word      = {opcode, rDadrs, flag, fmt_imm ? imm : {rAadrs, rBadrs, 2'b00}};
        // reset is folded in so in_ready drops the instant reset asserts
        in_ready  = enable && !reset && (cnt_q < FULL);
        out_valid = enable && (cnt_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        mem_d     = mem_q;
        if (push) mem_d[wp_q] = word;
        wp_d      = push ? wp_q + 1'b1 : wp_q;
        rp_d      = pop ? rp_q + 1'b1 : rp_q;
        cnt_d     = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
        instruct  = mem_q[rp_q];
        count     = cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
endmodule
